bin_accumulator: RTL and testbench

- Pitch-shift bin remapper stage in the phase vocoder, directly downstream of the fixed-point rounding stage.
- Accepts a stream of (rounded target-bin index, magnitude) pairs, one per source FFT bin.
- Sums magnitudes that land on the same target bin into a frame buffer.
- After the frame ends, streams the shifted spectrum out in bin order and clears the buffer for the next frame.

---
 rtl/bin_accumulator.sv | 242 ++++++++++++++++++++++++
 tb/tb_bin_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_accumulator.sv
// Pitch-shift bin remapper: accumulates (target bin, magnitude) beats into a
// frame buffer, then drains the buffer in bin order while zeroing it.
module bin_accumulator #(
  parameter int INT_WIDTH  = 11,
  parameter int FRAC_WIDTH = 21,
  parameter int MAG_WIDTH  = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] in_index,
  input  logic [MAG_WIDTH-1:0]            in_mag,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [MAG_WIDTH-1:0]            out_mag,
  output logic [ADDR_WIDTH-1:0]           out_bin,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [15:0]                     dropped
);

  localparam int unsigned N_BINS = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  flush_cnt_q, flush_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [15:0]           dropped_q, dropped_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [MAG_WIDTH-1:0]  s1_mag_q, s1_mag_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [MAG_WIDTH-1:0]  s2_sum_q, s2_sum_d;

  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_WIDTH-1:0] rd_bin_q, rd_bin_d;
  logic                  rd_done_q, rd_done_d;
  logic                  rd_pend_q, rd_pend_d;

  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [MAG_WIDTH-1:0]  out_mag_q, out_mag_d;
  logic [ADDR_WIDTH-1:0] out_bin_q, out_bin_d;

  logic [MAG_WIDTH-1:0]  mem [N_BINS];
  logic [MAG_WIDTH-1:0]  rd_data_q;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [MAG_WIDTH-1:0]  ram_wdata;

  logic [INT_WIDTH-1:0]  tgt;
  logic                  oor, accept, acc_hit;
  logic [MAG_WIDTH-1:0]  old_val, sum;
  logic [MAG_WIDTH:0]    sum_wide;
  logic                  out_load, out_fire, drain_rd;
  logic                  unused_frac;

  assign tgt         = in_index[INT_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
  assign unused_frac = ^in_index[FRAC_WIDTH-1:0];
  assign oor         = (tgt >> ADDR_WIDTH) != '0;
  assign accept      = in_valid && (state_q == S_ACCUM);
  assign acc_hit     = accept && !oor;

  // The previous beat's write lands on the same edge as this beat's read, so
  // a matching address must take the stage-2 sum instead of the RAM data.
  always_comb begin
    old_val  = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_sum_q : rd_data_q;
    sum_wide = {1'b0, old_val} + {1'b0, s1_mag_q};
    sum      = sum_wide[MAG_WIDTH] ? '1 : sum_wide[MAG_WIDTH-1:0];
  end

  assign out_fire = out_valid_q && out_ready;
  assign out_load = (state_q == S_DRAIN) && rd_pend_q && (!out_valid_q || out_ready);
  // The first drain read is issued on the last flush edge to hit the latency.
  assign drain_rd = ((state_q == S_FLUSH) && flush_cnt_q) ||
                    ((state_q == S_DRAIN) && !rd_done_q && (!rd_pend_q || out_load));

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
    end else if (s1_valid_q) begin
      ram_we    = 1'b1;
      ram_waddr = s1_addr_q;
      ram_wdata = sum;
    end else if (drain_rd) begin
      ram_we    = 1'b1;
      ram_waddr = drain_addr_q;
    end
    if (acc_hit) begin
      ram_re    = 1'b1;
      ram_raddr = tgt[ADDR_WIDTH-1:0];
    end else if (drain_rd) begin
      ram_re    = 1'b1;
      ram_raddr = drain_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rd_data_q <= mem[ram_raddr];
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    dropped_d   = dropped_q;
    if (accept && oor && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ONE_A;
        if (clr_cnt_q == LAST_BIN) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (accept && in_last) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = 1'b1;
        if (flush_cnt_q) begin
          state_d    = S_DRAIN;
          dropped_d  = drop_cnt_q;
          drop_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (out_fire && out_last_q) state_d = S_ACCUM;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    s1_valid_d = acc_hit;
    s1_addr_d  = tgt[ADDR_WIDTH-1:0];
    s1_mag_d   = in_mag;
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_sum_d   = sum;
  end

  always_comb begin
    drain_addr_d = drain_addr_q;
    rd_bin_d     = rd_bin_q;
    rd_done_d    = rd_done_q;
    rd_pend_d    = rd_pend_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_mag_d    = out_mag_q;
    out_bin_d    = out_bin_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_mag_d   = rd_data_q;
      out_bin_d   = rd_bin_q;
      out_last_d  = (rd_bin_q == LAST_BIN);
      rd_pend_d   = 1'b0;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (drain_rd) begin
      drain_addr_d = drain_addr_q + ONE_A;
      rd_bin_d     = drain_addr_q;
      rd_done_d    = (drain_addr_q == LAST_BIN);
      rd_pend_d    = 1'b1;
    end
    if ((state_q == S_DRAIN) && out_fire && out_last_q) rd_done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      flush_cnt_q  <= 1'b0;
      drop_cnt_q   <= '0;
      dropped_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_mag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_sum_q     <= '0;
      drain_addr_q <= '0;
      rd_bin_q     <= '0;
      rd_done_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_mag_q    <= '0;
      out_bin_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      dropped_q    <= dropped_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_mag_q     <= s1_mag_d;
      s2_valid_q   <= s2_valid_d;
      s2_addr_q    <= s2_addr_d;
      s2_sum_q     <= s2_sum_d;
      drain_addr_q <= drain_addr_d;
      rd_bin_q     <= rd_bin_d;
      rd_done_q    <= rd_done_d;
      rd_pend_q    <= rd_pend_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_mag_q    <= out_mag_d;
      out_bin_q    <= out_bin_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_mag   = out_mag_q;
  assign out_bin   = out_bin_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_bin_accumulator.sv
// Directed bench for bin_accumulator: a bin-array model fills a scoreboard
// queue when a frame's last beat is driven; drain outputs are checked against it.
module tb_bin_accumulator;

  logic        clk;
  logic        rst_n;
  logic [9:0]  in_index;
  logic [7:0]  in_mag;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_mag;
  logic [3:0]  out_bin;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] dropped;

  bin_accumulator #(
    .INT_WIDTH (6),
    .FRAC_WIDTH(4),
    .MAG_WIDTH (8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_index (in_index),
    .in_mag   (in_mag),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_mag  (out_mag),
    .out_bin  (out_bin),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .dropped  (dropped)
  );

  typedef struct {
    int bin;
    int mag;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   model[16];
  int   exp_drop;
  int   exp_dropped;
  int   n_assert;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one beat at a falling edge; returns on the falling edge after the handshake.
  task automatic beat(input int ip, input int mag, input bit last);
    int   m;
    exp_t e;
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    in_index = {6'(ip), 4'($urandom_range(0, 15))};
    in_mag   = 8'(mag);
    in_valid = 1'b1;
    in_last  = last;
    if (ip < 16) begin
      m = model[ip] + mag;
      model[ip] = (m > 255) ? 255 : m;
    end else begin
      exp_drop++;
    end
    if (last) begin
      for (int k = 0; k < 16; k++) begin
        e.bin  = k;
        e.mag  = model[k];
        e.last = (k == 15);
        sb.push_back(e);
        model[k] = 0;
      end
      exp_dropped = exp_drop;
      exp_drop    = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called on the first falling edge after the in_last handshake; junk input
  // beats are offered throughout and must be ignored outside ACCUM.
  task automatic drain(input bit rand_ready);
    int lat;
    int guard;
    out_ready = 1'b1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_index = {6'($urandom_range(0, 15)), 4'd0};
      in_mag   = 8'($urandom_range(1, 255));
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'd4);
    chk("dropped_at_drain", 32'(dropped), 32'(exp_dropped));
    guard = 0;
    while (sb.size() > 0 && guard < 400) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_last   = 1'($urandom_range(0, 1));
      in_index  = {6'($urandom_range(0, 15)), 4'd0};
      if (out_valid === 1'b1) begin
        chk("out_bin", 32'(out_bin), 32'(sb[0].bin));
        chk("out_mag", 32'(out_mag), 32'(sb[0].mag));
        chk("out_last", 32'(out_last), 32'(sb[0].last));
        if (out_ready) void'(sb.pop_front());
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("drain_complete", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("out_valid_after_last", 32'(out_valid), 32'd0);
    chk("in_ready_after_last", 32'(in_ready), 32'd1);
    chk("dropped_held", 32'(dropped), 32'(exp_dropped));
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    exp_drop    = 0;
    exp_dropped = 0;
    rst_n       = 1'b0;
    in_index    = '0;
    in_mag      = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("clear_in_ready", 32'(in_ready), 32'd0);
      chk("clear_out_valid", 32'(out_valid), 32'd0);
      chk("clear_out_mag", 32'(out_mag), 32'd0);
      @(negedge clk);
    end
    chk("accum_in_ready", 32'(in_ready), 32'd1);
    chk("accum_dropped", 32'(dropped), 32'd0);

    // Identity mapping, bin k gets k+1.
    for (int k = 0; k < 16; k++) beat(k, k + 1, k == 15);
    drain(1'b0);

    // Back-to-back hits on one bin.
    beat(5, 10, 1'b0);
    beat(5, 20, 1'b0);
    beat(5, 30, 1'b0);
    beat(2, 7, 1'b1);
    drain(1'b0);

    // Saturation through the forwarding path.
    beat(3, 200, 1'b0);
    beat(3, 100, 1'b1);
    drain(1'b0);

    // Out-of-range targets.
    beat(16, 5, 1'b0);
    beat(63, 9, 1'b0);
    beat(7, 44, 1'b1);
    drain(1'b0);

    // Random frame with idle gaps, stalled drain.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      beat((i == 4) ? 20 : int'($urandom_range(0, 15)), int'($urandom_range(1, 255)), i == 11);
    end
    drain(1'b1);

    // Frame with no in-range beats still drains zeros.
    beat(40, 1, 1'b1);
    drain(1'b1);

    // Residue check after the random frame.
    beat(0, 9, 1'b1);
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
